// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART controller.
// Imported by the FIFO and the top level.
package uart_pkg;

  localparam int UART_WORD_SIZE = 8;

  localparam int OVF_DROP      = 0;
  localparam int OVF_OVERWRITE = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock ring FIFO with explicit pointer wrap, any depth >= 2.
// When full, a push without a pop is dropped or overwrites the oldest entry.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int WIDTH     = UART_WORD_SIZE,
  parameter  int DEPTH     = 16,
  parameter  int OVERWRITE = OVF_DROP,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_evt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_pop;
  logic             do_wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign dout_o    = mem_q[rd_q];
  assign do_pop    = pop_i && !empty_o;
  assign ovf_evt_o = push_i && full_o && !do_pop;
  assign do_wr     = push_i && (!ovf_evt_o || (OVERWRITE != 0));

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_wr) wr_d = nxt(wr_q);
    // An overwrite pushes the oldest entry out, so the head moves too
    if (do_pop || (do_wr && ovf_evt_o)) rd_d = nxt(rd_q);
    if (do_wr && !do_pop && !full_o) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_wr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/uart_buffered_ctrl.sv
// Buffered UART controller: host valid/ready side, engine level/pulse side,
// RX/TX ring FIFOs, overflow policy and occupancy status.
module uart_buffered_ctrl
  import uart_pkg::*;
#(
  parameter  int WORD_SIZE   = UART_WORD_SIZE,
  parameter  int RX_DEPTH    = 16,
  parameter  int TX_DEPTH    = 16,
  parameter  int RX_OVF_MODE = OVF_DROP,
  parameter  int RX_AFULL    = RX_DEPTH - 4,
  localparam int RCW         = $clog2(RX_DEPTH + 1),
  localparam int TCW         = $clog2(TX_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] tx_wdata,
  input  logic                 tx_wvalid,
  output logic                 tx_wready,
  output logic [WORD_SIZE-1:0] rx_rdata,
  output logic                 rx_rvalid,
  input  logic                 rx_rready,
  input  logic [WORD_SIZE-1:0] rxc_data,
  input  logic                 rxc_valid,
  output logic                 rxc_ack,
  output logic [WORD_SIZE-1:0] txc_data,
  output logic                 txc_send,
  input  logic                 txc_done,
  input  logic                 clr_ovf,
  output logic [RCW-1:0]       rx_count,
  output logic [TCW-1:0]       tx_count,
  output logic                 rx_overflow,
  output logic                 rx_almost_full,
  output logic                 tx_idle
);

  logic                 ack_q, ack_d;
  logic                 ovf_q, ovf_d;
  logic                 rx_push;
  logic                 rx_empty;
  logic                 rx_ovf_evt;
  logic                 rx_full_unused;
  logic                 tx_push;
  logic                 tx_pop;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_ovf_unused;
  logic [WORD_SIZE-1:0] tx_head;
  tx_state_t            st_q, st_d;
  logic                 send_q, send_d;
  logic [WORD_SIZE-1:0] txd_q, txd_d;

  // The engine holds valid until it sees ack, so skip the ack cycle
  assign rx_push = rxc_valid && !ack_q;
  assign ack_d   = rx_push;
  assign ovf_d   = rx_ovf_evt ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  uart_sync_fifo #(
    .WIDTH     (WORD_SIZE),
    .DEPTH     (RX_DEPTH),
    .OVERWRITE (RX_OVF_MODE)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (rx_push),
    .pop_i     (rx_rready),
    .din_i     (rxc_data),
    .dout_o    (rx_rdata),
    .count_o   (rx_count),
    .full_o    (rx_full_unused),
    .empty_o   (rx_empty),
    .ovf_evt_o (rx_ovf_evt)
  );

  assign tx_wready = !tx_full;
  assign tx_push   = tx_wvalid && !tx_full;

  uart_sync_fifo #(
    .WIDTH     (WORD_SIZE),
    .DEPTH     (TX_DEPTH),
    .OVERWRITE (OVF_DROP)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (tx_push),
    .pop_i     (tx_pop),
    .din_i     (tx_wdata),
    .dout_o    (tx_head),
    .count_o   (tx_count),
    .full_o    (tx_full),
    .empty_o   (tx_empty),
    .ovf_evt_o (tx_ovf_unused)
  );

  always_comb begin
    st_d   = st_q;
    send_d = send_q;
    txd_d  = txd_q;
    tx_pop = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop = 1'b1;
          txd_d  = tx_head;
          send_d = 1'b1;
          st_d   = BUSY;
        end
      end
      BUSY: begin
        if (txc_done) begin
          send_d = 1'b0;
          st_d   = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
      st_q   <= IDLE;
      send_q <= 1'b0;
      txd_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      ovf_q  <= ovf_d;
      st_q   <= st_d;
      send_q <= send_d;
      txd_q  <= txd_d;
    end
  end

  assign rxc_ack        = ack_q;
  assign txc_send       = send_q;
  assign txc_data       = txd_q;
  assign rx_overflow    = ovf_q;
  assign rx_rvalid      = !rx_empty;
  assign rx_almost_full = (rx_count >= RCW'(RX_AFULL));
  assign tx_idle        = tx_empty && (st_q == IDLE);

endmodule

// File: tb/tb_uart_buffered_ctrl.sv
// Directed bench: three controller instances (drop/4, overwrite/4, drop/5)
// share stimulus; expected values are hand-derived.
module tb_uart_buffered_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_wdata;
  logic       tx_wvalid;
  logic       rx_rready;
  logic [7:0] rxc_data;
  logic       rxc_valid;
  logic       txc_done;
  logic       clr_ovf;

  logic       wready [3];
  logic [7:0] rdata  [3];
  logic       rvalid [3];
  logic       ack    [3];
  logic [7:0] txdata [3];
  logic       send   [3];
  logic [2:0] rcount [3];
  logic [2:0] tcount [3];
  logic       ovf    [3];
  logic       afull  [3];
  logic       idle   [3];

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;

  always #5 clk = ~clk;

  uart_buffered_ctrl #(
    .WORD_SIZE(8), .RX_DEPTH(4), .TX_DEPTH(4),
    .RX_OVF_MODE(0), .RX_AFULL(3)
  ) u0 (
    .clk(clk), .rst(rst),
    .tx_wdata(tx_wdata), .tx_wvalid(tx_wvalid), .tx_wready(wready[0]),
    .rx_rdata(rdata[0]), .rx_rvalid(rvalid[0]), .rx_rready(rx_rready),
    .rxc_data(rxc_data), .rxc_valid(rxc_valid), .rxc_ack(ack[0]),
    .txc_data(txdata[0]), .txc_send(send[0]), .txc_done(txc_done),
    .clr_ovf(clr_ovf), .rx_count(rcount[0]), .tx_count(tcount[0]),
    .rx_overflow(ovf[0]), .rx_almost_full(afull[0]), .tx_idle(idle[0])
  );

  uart_buffered_ctrl #(
    .WORD_SIZE(8), .RX_DEPTH(4), .TX_DEPTH(4),
    .RX_OVF_MODE(1), .RX_AFULL(3)
  ) u1 (
    .clk(clk), .rst(rst),
    .tx_wdata(tx_wdata), .tx_wvalid(tx_wvalid), .tx_wready(wready[1]),
    .rx_rdata(rdata[1]), .rx_rvalid(rvalid[1]), .rx_rready(rx_rready),
    .rxc_data(rxc_data), .rxc_valid(rxc_valid), .rxc_ack(ack[1]),
    .txc_data(txdata[1]), .txc_send(send[1]), .txc_done(txc_done),
    .clr_ovf(clr_ovf), .rx_count(rcount[1]), .tx_count(tcount[1]),
    .rx_overflow(ovf[1]), .rx_almost_full(afull[1]), .tx_idle(idle[1])
  );

  uart_buffered_ctrl #(
    .WORD_SIZE(8), .RX_DEPTH(5), .TX_DEPTH(4),
    .RX_OVF_MODE(0), .RX_AFULL(3)
  ) u2 (
    .clk(clk), .rst(rst),
    .tx_wdata(tx_wdata), .tx_wvalid(tx_wvalid), .tx_wready(wready[2]),
    .rx_rdata(rdata[2]), .rx_rvalid(rvalid[2]), .rx_rready(rx_rready),
    .rxc_data(rxc_data), .rxc_valid(rxc_valid), .rxc_ack(ack[2]),
    .txc_data(txdata[2]), .txc_send(send[2]), .txc_done(txc_done),
    .clr_ovf(clr_ovf), .rx_count(rcount[2]), .tx_count(tcount[2]),
    .rx_overflow(ovf[2]), .rx_almost_full(afull[2]), .tx_idle(idle[2])
  );

  always @(negedge clk) if (ack[0]) ack_cnt++;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_word(input logic [7:0] w);
    int n;
    rxc_data  = w;
    rxc_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack[0] && n < 8);
    chk("rx_ack", ack[0], 1);
    rxc_valid = 1'b0;
    tick();
  endtask

  task automatic pop();
    rx_rready = 1'b1;
    tick();
    rx_rready = 1'b0;
  endtask

  logic [7:0] q [$];
  logic [7:0] exp_words [3];

  initial begin
    rst = 1'b1; tx_wdata = '0; tx_wvalid = 1'b0; rx_rready = 1'b0;
    rxc_data = '0; rxc_valid = 1'b0; txc_done = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rvalid", rvalid[0], 0);
    chk("rst_wready", wready[0], 1);
    chk("rst_idle",   idle[0],   1);
    chk("rst_send",   send[0],   0);
    chk("rst_ack",    ack[0],    0);
    chk("rst_ovf",    ovf[0],    0);
    chk("rst_rcount", rcount[0], 0);
    chk("rst_txdata", txdata[0], 0);

    // RX burst
    ack_cnt = 0;
    exp_words = '{8'h11, 8'h22, 8'h33};
    foreach (exp_words[i]) rx_word(exp_words[i]);
    chk("burst_acks",  ack_cnt,   3);
    chk("burst_count", rcount[0], 3);
    chk("burst_afull", afull[0],  1);
    foreach (exp_words[i]) begin
      chk("burst_rvalid", rvalid[0], 1);
      chk("burst_rdata",  rdata[0],  exp_words[i]);
      pop();
      if (i == 0) chk("afull_drop", afull[0], 0);
    end
    chk("burst_empty", rcount[0], 0);
    chk("burst_rv0",   rvalid[0], 0);

    // TX stream
    tx_wdata = 8'hA5; tx_wvalid = 1'b1; tick();
    tx_wdata = 8'h5A; tick();
    tx_wvalid = 1'b0;
    chk("tx_lat_send", send[0],   1);
    chk("tx_data0",    txdata[0], 8'hA5);
    chk("tx_cnt_wp",   tcount[0], 1);
    chk("tx_busy",     idle[0],   0);
    repeat (9) tick();
    chk("tx_hold", send[0], 1);
    txc_done = 1'b1; tick(); txc_done = 1'b0;
    chk("tx_gap",     send[0],   0);
    chk("tx_gap_cnt", tcount[0], 1);
    tick();
    chk("tx_send1", send[0],   1);
    chk("tx_data1", txdata[0], 8'h5A);
    chk("tx_cnt0",  tcount[0], 0);
    repeat (9) tick();
    txc_done = 1'b1; tick(); txc_done = 1'b0;
    chk("tx_end_send", send[0], 0);
    chk("tx_end_idle", idle[0], 1);
    txc_done = 1'b1; tick(); txc_done = 1'b0;
    chk("tx_done_idle", send[0], 0);
    chk("tx_done_idl2", idle[0], 1);

    // Overflow: u0 drops, u1 overwrites, u2 (depth 5) keeps 1..5
    for (int i = 1; i <= 6; i++) begin
      rx_word(8'(i));
      if (i == 4) begin
        chk("ovf_pre",  ovf[0],    0);
        chk("ovf_full", rcount[0], 4);
      end
      if (i >= 5) begin
        chk("ovw_cnt",  rcount[1], 4);
        chk("drop_cnt", rcount[0], 4);
      end
    end
    chk("ovf_drop", ovf[0], 1);
    chk("ovf_ovw",  ovf[1], 1);
    for (int k = 0; k < 4; k++) begin
      chk("drop_rdata", rdata[0], k + 1);
      chk("ovw_rdata",  rdata[1], k + 3);
      pop();
    end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_clr", ovf[0], 0);
    chk("d5_rdata", rdata[2], 5);
    pop();
    chk("pop_empty", rcount[0], 0);
    chk("d5_empty",  rcount[2], 0);

    // Set beats a simultaneous clear
    for (int i = 0; i < 4; i++) rx_word(8'h40 + 8'(i));
    clr_ovf = 1'b1; rxc_data = 8'h44; rxc_valid = 1'b1;
    tick();
    chk("ovf_set_wins", ovf[0], 1);
    rxc_valid = 1'b0;
    tick();
    chk("ovf_clr_held", ovf[0], 0);
    clr_ovf = 1'b0;
    repeat (5) pop();
    chk("drain_u0", rcount[0], 0);
    chk("drain_u2", rcount[2], 0);

    // Steady occupancy of 4 with push+pop together across the wrap
    q.delete();
    for (int i = 0; i < 4; i++) begin
      rx_word(8'h80 + 8'(i));
      q.push_back(8'h80 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      chk("wrap_d5", rdata[2], q[0]);
      chk("wrap_d4", rdata[0], q[0]);
      rxc_data = 8'h90 + 8'(i); rxc_valid = 1'b1; rx_rready = 1'b1;
      tick();
      rxc_valid = 1'b0; rx_rready = 1'b0;
      void'(q.pop_front());
      q.push_back(8'h90 + 8'(i));
      tick();
    end
    chk("wrap_cnt5", rcount[2], 4);
    chk("wrap_cnt4", rcount[0], 4);
    chk("wrap_ovf4", ovf[0],    0);
    chk("wrap_ovf1", ovf[1],    0);
    chk("wrap_ovf5", ovf[2],    0);
    repeat (4) pop();

    // TX full, write rejected while the FSM pops
    tx_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_wdata = 8'hC0 + 8'(i);
      tick();
    end
    tx_wvalid = 1'b0;
    chk("txf_cnt",    tcount[0], 4);
    chk("txf_wready", wready[0], 0);
    txc_done = 1'b1; tick(); txc_done = 1'b0;
    tx_wdata = 8'hEE; tx_wvalid = 1'b1;
    tick();
    tx_wvalid = 1'b0;
    chk("txf_rej_cnt", tcount[0], 3);
    chk("txf_send",    send[0],   1);
    chk("txf_data",    txdata[0], 8'hC1);
    chk("txf_wready1", wready[0], 1);

    // Reset while BUSY with 3 queued and an overflowed RX FIFO
    for (int i = 0; i < 5; i++) rx_word(8'h60 + 8'(i));
    chk("pre_rst_ovf", ovf[0],    1);
    chk("pre_rst_rv",  rvalid[0], 1);
    chk("pre_rst_tx",  tcount[0], 3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_send",   send[0],   0);
    chk("mrst_tcnt",   tcount[0], 0);
    chk("mrst_rvalid", rvalid[0], 0);
    chk("mrst_ovf",    ovf[0],    0);
    chk("mrst_idle",   idle[0],   1);
    chk("mrst_txdata", txdata[0], 0);
    tick();
    chk("mrst_quiet",  send[0],   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
